// File: rtl/sao_stat_pkg.sv
// Shared constants, FSM state type and signed accumulator limits for the
// SAO statistics category scheduler (s51 stage).
package sao_stat_pkg;

   localparam int PIX5          = 5;
   localparam int DIFF_CLIP_BIT = 4;
   localparam int S51_W         = DIFF_CLIP_BIT + 4;
   localparam int N_BO_TYPE     = 5;
   localparam int N_CAT_BO      = 4;
   localparam int N_CAT_EO      = 5;
   localparam int ACC_W         = 16;
   localparam int GRP_W         = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   function automatic int acc_max(input int w);
      return (32'sd1 <<< (w - 1)) - 32'sd1;
   endfunction

   function automatic int acc_min(input int w);
      return -(32'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/sao_stat_acc_bank.sv
// Per-category signed accumulators with clear and add-at-index.
// SAO_STAT_SAT_EN selects saturation instead of two's-complement wrap.
module sao_stat_acc_bank
   import sao_stat_pkg::*;
#(
   parameter int N_CAT = N_CAT_BO,
   parameter int IDX_W = 2
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      i_clr,
   input  logic                      i_add_en,
   input  logic [IDX_W-1:0]          i_idx,
   input  logic signed [S51_W-1:0]   i_val,
   output logic [N_CAT*ACC_W-1:0]    o_acc,
   output logic                      o_ovf
);

   localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(acc_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(acc_min(ACC_W));

   logic signed [ACC_W-1:0] r_acc [N_CAT];
   logic                    r_ovf;
   logic signed [ACC_W-1:0] w_cur;
   logic signed [ACC_W-1:0] w_new;
   logic signed [ACC_W:0]   w_sum;
   logic                    w_of;

   // One extra sum bit: overflow shows up as disagreement of the top two bits.
   always_comb begin
      w_cur = r_acc[i_idx];
      w_sum = {w_cur[ACC_W-1], w_cur} + {{(ACC_W+1-S51_W){i_val[S51_W-1]}}, i_val};
      w_of  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef SAO_STAT_SAT_EN
      if (w_of) begin
         w_new = w_sum[ACC_W] ? ACC_LO : ACC_HI;
      end else begin
         w_new = w_sum[ACC_W-1:0];
      end
`else
      w_new = w_sum[ACC_W-1:0];
`endif
   end

   // Accumulator storage and sticky overflow, cleared at the start of a pass.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < N_CAT; i++) begin
            r_acc[i] <= {ACC_W{1'b0}};
         end
         r_ovf <= 1'b0;
      end else if (i_clr) begin
         for (int i = 0; i < N_CAT; i++) begin
            r_acc[i] <= {ACC_W{1'b0}};
         end
         r_ovf <= 1'b0;
      end else if (i_add_en) begin
         r_acc[i_idx] <= w_new;
         if (w_of) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Packed view of the accumulators.
   always_comb begin
      o_acc = {(N_CAT*ACC_W){1'b0}};
      for (int i = 0; i < N_CAT; i++) begin
         o_acc[i*ACC_W +: ACC_W] = r_acc[i];
      end
   end

   assign o_ovf = r_ovf;

endmodule

// File: rtl/sao_stat_cate_sched.sv
// Category sweep controller for the SAO statistics 5-pixel adder tree.
// Build option SAO_STAT_SAT_EN (in the accumulator bank) selects saturation.
module sao_stat_cate_sched
   import sao_stat_pkg::*;
#(
   parameter int N_CAT = N_CAT_BO
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      start,
   input  logic [GRP_W-1:0]          num_groups,
   input  logic [N_BO_TYPE-1:0]      cate_base,
   input  logic                      grp_valid,
   output logic                      grp_ready,
   output logic [N_BO_TYPE-1:0]      cate_target,
   output logic                      en,
   output logic                      isWorking_stat,
   input  logic signed [S51_W-1:0]   s51,
   output logic [N_CAT*ACC_W-1:0]    acc_out,
   output logic                      busy,
   output logic                      done,
   output logic                      ovf
);

   localparam int             K_W    = (N_CAT > 1) ? $clog2(N_CAT) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_CAT - 1);

   state_e               r_state;
   logic [GRP_W-1:0]     r_num_groups;
   logic [GRP_W-1:0]     r_grp_cnt;
   logic [N_BO_TYPE-1:0] r_base;
   logic [K_W-1:0]       r_k;
   logic [N_BO_TYPE-1:0] r_cate_target;
   logic                 r_grp_ready;
   logic                 r_done;
   logic                 r_busy;

   logic                 w_issue_fire;
   logic                 w_clr;
   logic                 w_add;
   logic [K_W-1:0]       w_k_nxt;
   logic [GRP_W-1:0]     w_grp_nxt;
   logic [N_BO_TYPE-1:0] w_cate_nxt;

   assign w_issue_fire = (r_state == ISSUE) && grp_valid;
   assign w_clr        = (r_state == IDLE) && start;
   assign w_add        = (r_state == CAPTURE);
   assign w_k_nxt      = r_k + K_W'(1);
   assign w_grp_nxt    = r_grp_cnt + GRP_W'(1);
   // Truncation to N_BO_TYPE bits gives the band wrap (30,31,0,1).
   assign w_cate_nxt   = r_base + N_BO_TYPE'(w_k_nxt);

   // Sweep FSM; cate_target/grp_ready/done/busy are registered for the next state.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state       <= IDLE;
         r_num_groups  <= {GRP_W{1'b0}};
         r_grp_cnt     <= {GRP_W{1'b0}};
         r_base        <= {N_BO_TYPE{1'b0}};
         r_k           <= {K_W{1'b0}};
         r_cate_target <= {N_BO_TYPE{1'b0}};
         r_grp_ready   <= 1'b0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_grp_ready <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_num_groups <= num_groups;
                  r_base       <= cate_base;
                  r_k          <= {K_W{1'b0}};
                  r_grp_cnt    <= {GRP_W{1'b0}};
                  if (num_groups == {GRP_W{1'b0}}) begin
                     r_state       <= DONE;
                     r_done        <= 1'b1;
                     r_busy        <= 1'b0;
                     r_cate_target <= {N_BO_TYPE{1'b0}};
                  end else begin
                     r_state       <= ISSUE;
                     r_busy        <= 1'b1;
                     r_cate_target <= cate_base;
                  end
               end
            end
            ISSUE: begin
               if (grp_valid) begin
                  r_state <= CAPTURE;
                  if (r_k == K_LAST) begin
                     r_grp_ready <= 1'b1;
                  end
               end
            end
            CAPTURE: begin
               if (r_k == K_LAST) begin
                  r_k       <= {K_W{1'b0}};
                  r_grp_cnt <= w_grp_nxt;
                  if (w_grp_nxt == r_num_groups) begin
                     r_state       <= DONE;
                     r_done        <= 1'b1;
                     r_busy        <= 1'b0;
                     r_cate_target <= {N_BO_TYPE{1'b0}};
                  end else begin
                     r_state       <= ISSUE;
                     r_cate_target <= r_base;
                  end
               end else begin
                  r_k           <= w_k_nxt;
                  r_state       <= ISSUE;
                  r_cate_target <= w_cate_nxt;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state       <= IDLE;
               r_busy        <= 1'b0;
               r_cate_target <= {N_BO_TYPE{1'b0}};
            end
         endcase
      end
   end

   sao_stat_acc_bank #(
      .N_CAT (N_CAT),
      .IDX_W (K_W)
   ) u_acc_bank (
      .clk      (clk),
      .arst_n   (arst_n),
      .i_clr    (w_clr),
      .i_add_en (w_add),
      .i_idx    (r_k),
      .i_val    (s51),
      .o_acc    (acc_out),
      .o_ovf    (ovf)
   );

   // The adder wants en in the same cycle the upstream group is valid.
   assign en             = w_issue_fire;
   assign isWorking_stat = w_issue_fire;
   assign grp_ready      = r_grp_ready;
   assign cate_target    = r_cate_target;
   assign done           = r_done;
   assign busy           = r_busy;

endmodule

// File: tb/tb_sao_stat_cate_sched.sv
// Self-checking bench for sao_stat_cate_sched: directed table plus random
// passes checked against an arithmetic model of the per-category sums.
module tb_sao_stat_cate_sched;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start;
   logic [9:0]  num_groups;
   logic [4:0]  cate_base;
   logic        grp_valid;
   logic        grp_ready;
   logic [4:0]  cate_target;
   logic        en;
   logic        isWorking_stat;
   logic signed [7:0] s51;
   logic [63:0] acc_out;
   logic        busy;
   logic        done;
   logic        ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   int val_tbl [0:511][0:31];
   int st      [0:511];
   bit m_ovf;

   typedef struct {
      int groups;
      int base;
      int s51v;
      int stall_grp;
      int stall_len;
      int busy_at;
      int exp_acc;
      int exp_lat;
      int exp_ovf;
      int exp_rdy;
   } vec_t;

   vec_t vecs [5];

`ifdef SAO_STAT_SAT_EN
   localparam int OVF_ACC = 32767;
`else
   localparam int OVF_ACC = -27436;
`endif

   sao_stat_cate_sched dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .start          (start),
      .num_groups     (num_groups),
      .cate_base      (cate_base),
      .grp_valid      (grp_valid),
      .grp_ready      (grp_ready),
      .cate_target    (cate_target),
      .en             (en),
      .isWorking_stat (isWorking_stat),
      .s51            (s51),
      .acc_out        (acc_out),
      .busy           (busy),
      .done           (done),
      .ovf            (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   // Sum of the values seen by category (base+k) mod 32, with 16-bit limits.
   function automatic int model_acc(input int g_n, input int base, input int k);
      int acc = 0;
      int s;
      for (int g = 0; g < g_n; g++) begin
         s = acc + val_tbl[g][(base + k) % 32];
         if (s > 32767 || s < -32768) begin
            m_ovf = 1'b1;
`ifdef SAO_STAT_SAT_EN
            s = (s > 32767) ? 32767 : -32768;
`else
            s = (s > 32767) ? s - 65536 : s + 65536;
`endif
         end
         acc = s;
      end
      return acc;
   endfunction

   function automatic int acc_k(input int k);
      logic [63:0] v;
      v = acc_out;
      return int'($signed(v[k*16 +: 16]));
   endfunction

   task automatic run_pass(input string tag, input int g_n, input int base, input int busy_at,
                           input bit has_tbl, input int t_acc, input int t_lat,
                           input int t_ovf, input int t_rdy);
      int g = 0, stall_left, cyc = 0, en_cnt = 0, cate_err = 0, viol = 0, rdy_cnt = 0;
      int lat = -1, exp_lat, exp_cate;
      int exp_acc [N];
      bit got_done = 1'b0;
      logic [63:0] exp_pack;
      exp_lat = (g_n == 0) ? 1 : g_n * 2 * N + 1;
      for (int i = 0; i < g_n; i++) exp_lat += st[i];
      m_ovf = 1'b0;
      for (int k = 0; k < N; k++) exp_acc[k] = model_acc(g_n, base, k);
      @(posedge clk); #1;
      start = 1'b1; num_groups = g_n[9:0]; cate_base = base[4:0];
      grp_valid = 1'b0; s51 = 8'sd0; stall_left = st[0];
      while (!got_done && cyc < 4000) begin
         @(posedge clk); cyc++; #1;
         start = (busy_at != 0) && (cyc == busy_at);
         if (start) num_groups = 10'd7;
         s51 = (g < g_n) ? 8'(val_tbl[g][cate_target]) : 8'sd0;
         if (grp_ready) begin
            rdy_cnt++; g++;
            stall_left = (g < g_n) ? st[g] : 0;
            grp_valid = 1'b0;
         end else if (stall_left > 0) begin
            grp_valid = 1'b0; stall_left--;
         end else begin
            grp_valid = (g < g_n);
         end
         @(negedge clk);
         if (en !== isWorking_stat) viol++;
         if (!grp_valid && en) viol++;
         if (en) begin
            exp_cate = (base + (en_cnt % N)) % 32;
            if (int'(cate_target) != exp_cate) cate_err++;
            en_cnt++;
         end
         if (done) begin
            got_done = 1'b1; lat = cyc;
            if (busy) viol++;
         end else if (busy !== 1'b1) begin
            viol++;
         end
      end
      start = 1'b0; grp_valid = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_en_count"}, en_cnt, g_n * N);
      check({tag, "_cate_seq_errs"}, cate_err, 0);
      check({tag, "_ctrl_viol"}, viol, 0);
      check({tag, "_grp_ready_cnt"}, rdy_cnt, g_n);
      for (int k = 0; k < N; k++) check($sformatf("%s_acc%0d", tag, k), acc_k(k), exp_acc[k]);
      check({tag, "_ovf"}, ovf, m_ovf);
      if (has_tbl) begin
         for (int k = 0; k < N; k++) check($sformatf("%s_tbl_acc%0d", tag, k), acc_k(k), t_acc);
         check({tag, "_tbl_lat"}, lat, t_lat);
         check({tag, "_tbl_ovf"}, ovf, t_ovf);
         check({tag, "_tbl_rdy"}, rdy_cnt, t_rdy);
      end
      @(negedge clk);
      check({tag, "_idle_outs"}, {done, busy, grp_ready, en, cate_target}, 0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) exp_pack[k*16 +: 16] = exp_acc[k][15:0];
      check({tag, "_acc_hold"}, acc_out, exp_pack);
   endtask

   task automatic fill_const(input int g_n, input int v, input int sg, input int sl);
      for (int g = 0; g < 512; g++) begin
         st[g] = (g == sg) ? sl : 0;
         for (int c = 0; c < 32; c++) val_tbl[g][c] = (g < g_n) ? v : 0;
      end
   endtask

   task automatic fill_rand(input int g_n);
      for (int g = 0; g < 512; g++) begin
         st[g] = (g < g_n) ? int'($urandom_range(3)) : 0;
         for (int c = 0; c < 32; c++) val_tbl[g][c] = int'($urandom_range(255)) - 128;
      end
   endtask

   initial begin
      int gr, bs, ba;
      vecs[0] = '{1,   3,  5,  -1, 0, 0, 5,       9,    0, 1};
      vecs[1] = '{2,  30, -2,  -1, 0, 5, -4,      17,   0, 2};
      vecs[2] = '{2,   0,  5,   1, 3, 0, 10,      20,   0, 2};
      vecs[3] = '{0,   7,  9,  -1, 0, 0, 0,       1,    0, 0};
      vecs[4] = '{300, 10, 127, -1, 0, 0, OVF_ACC, 2401, 1, 300};

      arst_n = 1'b0; start = 1'b0; num_groups = 10'd0; cate_base = 5'd0;
      grp_valid = 1'b0; s51 = 8'sd0;
      #12;
      check("reset_ctrl", {grp_ready, cate_target, en, isWorking_stat, busy, done, ovf}, 0);
      check("reset_acc", acc_out, 0);
      @(negedge clk); arst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         fill_const(vecs[i].groups, vecs[i].s51v, vecs[i].stall_grp, vecs[i].stall_len);
         run_pass($sformatf("vec%0d", i), vecs[i].groups, vecs[i].base, vecs[i].busy_at,
                  1'b1, vecs[i].exp_acc, vecs[i].exp_lat, vecs[i].exp_ovf, vecs[i].exp_rdy);
      end

      for (int r = 0; r < 8; r++) begin
         gr = int'($urandom_range(1, 6));
         bs = int'($urandom_range(0, 31));
         ba = (r % 2 == 1) ? int'($urandom_range(2, 8)) : 0;
         fill_rand(gr);
         run_pass($sformatf("rand%0d", r), gr, bs, ba, 1'b0, 0, 0, 0, 0);
      end

      // Reset during the first CAPTURE of the second group.
      fill_const(3, 7, -1, 0);
      @(posedge clk); #1;
      start = 1'b1; num_groups = 10'd3; cate_base = 5'd4; grp_valid = 1'b1; s51 = 8'sd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("rst_mid_busy", busy, 1);
      check("rst_mid_cate", cate_target, 4);
      check("rst_mid_acc0", acc_k(0), 7);
      arst_n = 1'b0;
      #1;
      check("rst_mid_ctrl", {grp_ready, cate_target, en, isWorking_stat, busy, done, ovf}, 0);
      check("rst_mid_acc", acc_out, 0);
      @(negedge clk);
      arst_n = 1'b1; grp_valid = 1'b0; s51 = 8'sd0;
      fill_rand(3);
      run_pass("post_rst", 3, 29, 0, 1'b0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
